// File: rtl/mode7_scanline_scheduler_if.sv
// rtl/mode7_scanline_scheduler_if.sv - frame/line control, corner and result bundle for the mode-7 scanline scheduler
interface mode7_scanline_scheduler_if #(
    parameter int CORNER_W = 29
);
    logic                       frame_start;
    logic signed [CORNER_W-1:0] a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v;
    logic                       line_req;
    logic [9:0]                 line_y;
    logic [7:0]                 recip_n;
    logic [16:0]                recip_val;
    logic signed [35:0]         left_u, left_v;
    logic signed [32:0]         u_stride, v_stride;
    logic                       busy;
    logic                       line_done;
    logic                       overrun;

    modport master (
        output frame_start, a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v,
        output line_req, line_y, recip_val,
        input  recip_n, left_u, left_v, u_stride, v_stride, busy, line_done, overrun
    );

    modport slave (
        input  frame_start, a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v,
        input  line_req, line_y, recip_val,
        output recip_n, left_u, left_v, u_stride, v_stride, busy, line_done, overrun
    );
endinterface

// File: rtl/mode7_scanline_scheduler.sv
// rtl/mode7_scanline_scheduler.sv - per-scanline mode-7 floor edge/stride sequencer on one shared multiplier
module mode7_scanline_scheduler #(
    parameter int HORIZON_Y  = 240,
    parameter int STRIDE_MUL = 102,
    parameter int CORNER_W   = 29
) (
    input  logic                        clk_i,
    input  logic                        resetn_i,
    mode7_scanline_scheduler_if.slave   bus
);
    localparam logic [9:0] HY = 10'(HORIZON_Y);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_M_LU, S_M_LV, S_M_RU, S_M_RV, S_M_SU, S_M_SV, S_DONE
    } state_t;

    state_t                     state_q;
    logic signed [CORNER_W-1:0] sh_q [8];   // a_u a_v b_u b_v c_u c_v d_u d_v
    logic [16:0]                recip_q;
    logic signed [48:0]         prod_q;
    logic signed [35:0]         wl_u_q, wl_v_q, wr_u_q, wr_v_q;
    logic signed [32:0]         su_q;
    logic [7:0]                 recip_n_q;
    logic signed [35:0]         left_u_q, left_v_q;
    logic signed [32:0]         u_stride_q, v_stride_q;
    logic                       busy_q, line_done_q, overrun_q;

    logic signed [CORNER_W-1:0] far_c, near_c;
    logic signed [CORNER_W:0]   ediff;
    logic signed [36:0]         mul_a;
    logic signed [17:0]         mul_b;
    logic signed [48:0]         mul_p;

    function automatic logic signed [35:0] sext36(input logic signed [CORNER_W-1:0] x);
        return {{(36-CORNER_W){x[CORNER_W-1]}}, x};
    endfunction

    // The single multiplier: edge states scale a coarse corner delta by 1/(y-H), stride states scale the span.
    always_comb begin
        far_c  = '0;
        near_c = '0;
        mul_a  = '0;
        mul_b  = '0;
        case (state_q)
            S_M_LU:  begin far_c = sh_q[0]; near_c = sh_q[4]; end
            S_M_LV:  begin far_c = sh_q[1]; near_c = sh_q[5]; end
            S_M_RU:  begin far_c = sh_q[2]; near_c = sh_q[6]; end
            S_M_RV:  begin far_c = sh_q[3]; near_c = sh_q[7]; end
            default: ;
        endcase
        ediff = {far_c[CORNER_W-1], far_c} - {near_c[CORNER_W-1], near_c};
        case (state_q)
            S_M_LU, S_M_LV, S_M_RU, S_M_RV: begin
                mul_a = {{(36-CORNER_W){ediff[CORNER_W]}}, ediff >>> 16};
                mul_b = {1'b0, recip_q};
            end
            S_M_SU: begin
                mul_a = {wr_u_q[35], wr_u_q} - {wl_u_q[35], wl_u_q};
                mul_b = 18'(STRIDE_MUL);
            end
            S_M_SV: begin
                mul_a = {wr_v_q[35], wr_v_q} - {wl_v_q[35], wl_v_q};
                mul_b = 18'(STRIDE_MUL);
            end
            default: ;
        endcase
        mul_p = 49'(mul_a * mul_b);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 8; i++) sh_q[i] <= '0;
            recip_q     <= '0;
            prod_q      <= '0;
            wl_u_q      <= '0;
            wl_v_q      <= '0;
            wr_u_q      <= '0;
            wr_v_q      <= '0;
            su_q        <= '0;
            recip_n_q   <= '0;
            left_u_q    <= '0;
            left_v_q    <= '0;
            u_stride_q  <= '0;
            v_stride_q  <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            if (bus.frame_start) begin
                // Snapshot wins over everything: abort any line in flight, drop a coincident request.
                sh_q[0]   <= bus.a_u;
                sh_q[1]   <= bus.a_v;
                sh_q[2]   <= bus.b_u;
                sh_q[3]   <= bus.b_v;
                sh_q[4]   <= bus.c_u;
                sh_q[5]   <= bus.c_v;
                sh_q[6]   <= bus.d_u;
                sh_q[7]   <= bus.d_v;
                overrun_q <= 1'b0;
                busy_q    <= 1'b0;
                state_q   <= S_IDLE;
            end else begin
                if (bus.line_req && state_q != S_IDLE) overrun_q <= 1'b1;
                case (state_q)
                    S_IDLE: begin
                        if (bus.line_req) begin
                            if (bus.line_y >= HY) begin
                                recip_n_q <= 8'(bus.line_y - HY);
                                busy_q    <= 1'b1;
                                state_q   <= S_FETCH;
                            end else begin
                                line_done_q <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: state_q <= S_WAIT;
                    S_WAIT: begin
                        recip_q <= bus.recip_val;
                        state_q <= S_M_LU;
                    end
                    S_M_LU: begin
                        prod_q  <= mul_p;
                        state_q <= S_M_LV;
                    end
                    S_M_LV: begin
                        wl_u_q  <= sext36(sh_q[4]) + prod_q[35:0];
                        prod_q  <= mul_p;
                        state_q <= S_M_RU;
                    end
                    S_M_RU: begin
                        wl_v_q  <= sext36(sh_q[5]) + prod_q[35:0];
                        prod_q  <= mul_p;
                        state_q <= S_M_RV;
                    end
                    S_M_RV: begin
                        wr_u_q  <= sext36(sh_q[6]) + prod_q[35:0];
                        prod_q  <= mul_p;
                        state_q <= S_M_SU;
                    end
                    S_M_SU: begin
                        wr_v_q  <= sext36(sh_q[7]) + prod_q[35:0];
                        prod_q  <= mul_p;
                        state_q <= S_M_SV;
                    end
                    S_M_SV: begin
                        su_q    <= prod_q[48:16];
                        prod_q  <= mul_p;
                        state_q <= S_DONE;
                    end
                    S_DONE: begin
                        left_u_q    <= wl_u_q;
                        left_v_q    <= wl_v_q;
                        u_stride_q  <= su_q;
                        v_stride_q  <= prod_q[48:16];
                        line_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.recip_n   = recip_n_q;
    assign bus.left_u    = left_u_q;
    assign bus.left_v    = left_v_q;
    assign bus.u_stride  = u_stride_q;
    assign bus.v_stride  = v_stride_q;
    assign bus.busy      = busy_q;
    assign bus.line_done = line_done_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: doc/mode7_scanline_scheduler.md
Name: mode7_scanline_scheduler

Overview:
Sequences the per-scanline floor math of the mode-7 renderer over one shared signed multiplier. On each line request it fetches 1/(y-HORIZON_Y) from the reciprocal ROM and interpolates the frame's frustum corners into left-edge u/v. It then computes the right edge and the per-pixel u/v strides. Results are handed to the pixel stepper before x=0 of the next line. It sits between VGASyncGen/frame logic and the u/v stepping datapath.

Parameters:
HORIZON_Y, 240, first floor scanline; requests with line_y < HORIZON_Y are not computed
STRIDE_MUL, 102, 0.16 scale factor for span-to-stride (~65536/640)
CORNER_W, 29, signed width of corner coordinates (6 map + 5 texture + 16 frac + 2 guard)

Ports:
clk  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at vblank; snapshots corners
a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v  in  CORNER_W each  signed frustum corners (far-left, far-right, near-left, near-right)
line_req  in  1  one-cycle pulse: compute parameters for line_y
line_y  in  10  scanline to compute; sampled with line_req
recip_n  out  8  reciprocal ROM index, (line_y-HORIZON_Y)[7:0]
recip_val  in  17  ROM result, unsigned 0.16, valid 1 cycle after recip_n changes
left_u, left_v  out  36 each  signed left-edge texture position
u_stride, v_stride  out  33 each  signed per-pixel step
busy  out  1  computation in progress
line_done  out  1  one-cycle pulse: outputs updated this cycle
overrun  out  1  sticky: line_req arrived while busy

Behaviour:
- Reset (async, resetn low): all outputs 0, FSM IDLE, corner shadows 0. Release is synchronous to clk.
- frame_start: copies the eight corner inputs into shadow registers. All math uses shadows only, so mid-frame corner changes are invisible. Clears overrun.
- frame_start while busy: abort to IDLE. Outputs keep their last values. No line_done. frame_start has priority over a same-cycle line_req, which is dropped.
- FSM: IDLE -> FETCH -> WAIT -> M_LU -> M_LV -> M_RU -> M_RV -> M_SU -> M_SV -> DONE -> IDLE.
- IDLE: on line_req with line_y >= HORIZON_Y, register recip_n = line_y-HORIZON_Y and go to FETCH. If line_y < HORIZON_Y, pulse line_done next cycle, leave outputs unchanged, stay IDLE.
- FETCH/WAIT: wait out the ROM latency. recip_val is captured into a working register at the end of WAIT.
- M_LU/M_LV/M_RU/M_RV: one multiply per state, operands muxed onto the single multiplier.
  - Operands are ((far - near) >>> 16), with the subtraction done at CORNER_W+1 bits and kept as a 14-bit signed value, times zero-extended recip_val.
  - Each product is added to the near corner (sign-extended to 36 bits) in the following cycle, into working regs wl_u, wl_v, wr_u, wr_v.
- M_SU/M_SV: stride = ((wr - wl) * STRIDE_MUL) >>> 16, truncated to 33 bits signed.
- DONE: left_u, left_v, u_stride and v_stride update together on one edge, and line_done pulses in that cycle. Outputs never show partial results.
- Latency: line_req sampled on edge N, line_done high and outputs valid after edge N+9. busy is high from edge N+1 through edge N+9.
- line_req while busy: ignored and overrun set (sticky until frame_start or reset).
- Arithmetic wraps in two's complement; no saturation. recip_val = 0x10000 (n=0) is legal.
- Multiplier use is exclusively FSM-controlled, so there is no combinational path from inputs to outputs.

Test Plan:
- Reset: hold resetn low mid-computation -> all outputs 0, busy 0, overrun 0. After release, the first line_req completes normally.
- Basic line:
  - Setup: frame_start with c_u=d_u=0, a_u=0x80000, b_u=0x100000, all v corners 0. Then line_req line_y=300 with ROM returning recip_val=0x8000.
  - Expected: recip_n=60; left_u=262144, u_stride=408, left_v=0, v_stride=0; line_done at edge N+9.
- Negative direction: same setup with a_u=-0x80000, b_u=0, d_u=0 -> left_u=-262144, u_stride=408 (sign preserved through >>>).
- Sky line: line_req line_y=100 -> line_done next cycle, outputs unchanged, busy never asserted.
- Overrun and abort:
  - Second line_req 3 cycles after the first -> overrun=1, first result completes normally.
  - frame_start 5 cycles into a request -> no line_done, busy drops, overrun cleared.
- Shadowing: change a_u after frame_start, then issue line_req -> result uses the snapshot value.
